// File: rtl/rd_scoreboard_if.sv
// Issue/write-back/status bundle between decode, write-back and rd_scoreboard.
interface rd_scoreboard_if;
  logic        issue_valid;
  logic        issue_wr;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall;
  logic [31:0] pending;
  logic [6:0]  inflight;
  logic        err_underflow;

  modport master (
    output issue_valid, issue_wr, issue_rd, issue_rs1, issue_rs2,
           uses_rs1, uses_rs2, wb_valid, wb_rd, flush,
    input  stall, pending, inflight, err_underflow
  );

  modport slave (
    input  issue_valid, issue_wr, issue_rd, issue_rs1, issue_rs2,
           uses_rs1, uses_rs2, wb_valid, wb_rd, flush,
    output stall, pending, inflight, err_underflow
  );
endinterface

// File: rtl/rd_scoreboard.sv
// In-flight destination-register scoreboard with per-register pending counters.
// Optional: define SCB_WB_BYPASS_EN to let a same-cycle write-back release hazards.
module rd_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input logic           clk,
  input logic           reset_n,
  rd_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [6:0]       inflight_q, inflight_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic             busy1, busy2, full;
  logic             haz1, haz2, hazw, stall, accept;
  logic             inc_any, dec_any;

  always_comb begin
    cnt_rs1 = cnt_q[sb.issue_rs1];
    cnt_rs2 = cnt_q[sb.issue_rs2];
    cnt_rd  = cnt_q[sb.issue_rd];
    cnt_wb  = cnt_q[sb.wb_rd];
`ifdef SCB_WB_BYPASS_EN
    // Write-through register file: a retiring last write is already visible.
    busy1 = (cnt_rs1 != '0) &&
            !(sb.wb_valid && (sb.wb_rd == sb.issue_rs1) && (cnt_rs1 == ONE));
    busy2 = (cnt_rs2 != '0) &&
            !(sb.wb_valid && (sb.wb_rd == sb.issue_rs2) && (cnt_rs2 == ONE));
    full  = (cnt_rd == MAX_CNT) && !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));
`else
    busy1 = (cnt_rs1 != '0);
    busy2 = (cnt_rs2 != '0);
    full  = (cnt_rd == MAX_CNT);
`endif
    haz1   = sb.uses_rs1 && (sb.issue_rs1 != 5'd0) && busy1;
    haz2   = sb.uses_rs2 && (sb.issue_rs2 != 5'd0) && busy2;
    hazw   = sb.issue_wr && (sb.issue_rd != 5'd0) && full;
    stall  = sb.issue_valid && (haz1 || haz2 || hazw);
    accept = sb.issue_valid && !stall && !sb.flush;
  end

  assign sb.stall = stall;

  always_comb begin
    inc_any = accept && sb.issue_wr && (sb.issue_rd != 5'd0);
    dec_any = sb.wb_valid && (sb.wb_rd != 5'd0) && (cnt_wb != '0);
    err_d   = err_q ||
              (sb.wb_valid && (sb.wb_rd != 5'd0) && (cnt_wb == '0) && !sb.flush);

    cnt_d[0] = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sb.flush) begin
        cnt_d[i] = '0;
      end else if (inc_any && (sb.issue_rd == 5'(i)) &&
                   !(dec_any && (sb.wb_rd == 5'(i)))) begin
        cnt_d[i] = cnt_q[i] + ONE;
      end else if (dec_any && (sb.wb_rd == 5'(i)) &&
                   !(inc_any && (sb.issue_rd == 5'(i)))) begin
        cnt_d[i] = cnt_q[i] - ONE;
      end
    end

    // Issue and write-back on different registers cancel in the total.
    inflight_d = inflight_q;
    if (sb.flush) begin
      inflight_d = '0;
    end else if (inc_any && !dec_any) begin
      inflight_d = inflight_q + 7'd1;
    end else if (dec_any && !inc_any) begin
      inflight_d = inflight_q - 7'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    sb.pending = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      sb.pending[i] = (cnt_q[i] != '0);
    end
  end

  assign sb.inflight      = inflight_q;
  assign sb.err_underflow = err_q;

endmodule
